tx_frame_packer: RTL and testbench
==================================

# tx_frame_packer

Parametrised framer between a wide result word and the byte-wide UART transmitter (`TX_En_Sig`/`TX_Done_Sig`/`TX_Data` handshake). On request, it captures an `8*NBYTES`-bit word and sends an optional header byte, then the payload bytes MSB-first, then one checksum byte. It then pulses done. It replaces the fixed 5-byte, sum-only sender used by the decoders. It adds these features over that sender:
- configurable length;
- selectable checksum;
- a shadow capture, so the source word may change mid-frame;
- explicit re-arm rules.

## Interface
Parameters:
- `NBYTES`, 5: payload bytes per frame, 1–32.
- `HDR_EN`, 0: 1 = send `HDR_BYTE` before the payload.
- `HDR_BYTE`, 8'hAA: header value; it is not included in the checksum.
- `CK_MODE`, 0: 0 = two's-complement of the 8-bit payload sum; 1 = XOR of the payload bytes.

Ports:
- `CLK`  in  1  clock. One clock domain only.
- `RSTn`  in  1  asynchronous, active-low reset.
- `Frame_En`  in  1  level request, sampled only in IDLE.
- `Frame_Data`  in  8*NBYTES  payload; byte `NBYTES-1` (MSBs) is sent first.
- `Frame_Busy`  out  1  high from capture until the cycle `Frame_Done` drops.
- `Frame_Done`  out  1  one-cycle pulse at end of frame.
- `TX_Done_Sig`  in  1  one-cycle pulse from the UART when a byte has finished.
- `TX_En_Sig`  out  1  UART send enable, held until `TX_Done_Sig`.
- `TX_Data`  out  8  byte presented to the UART.

## Operation
- States: IDLE, LOAD, SEND, DONE.
- **IDLE:**
  - If `Frame_En` and `armed`:
    - capture `Frame_Data` into the shadow register;
    - clear the checksum accumulator;
    - set `idx=0`;
    - set `TX_Data` to `HDR_BYTE` if `HDR_EN`, else to payload byte 0 (accumulated);
    - set `Frame_Busy=1`;
    - go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD:** set `TX_En_Sig<=1`, go to SEND. A `TX_Done_Sig` arriving in LOAD is ignored.
- **SEND:** wait for `TX_Done_Sig`. On the pulse:
  - set `TX_En_Sig<=0`;
  - if the byte just sent was the checksum: set `Frame_Done<=1` and go to DONE;
  - else: load the next byte into `TX_Data` (next payload byte, or the checksum after the last payload byte) and go to LOAD.
- **DONE:**
  - set `Frame_Done<=0`, `Frame_Busy<=0`, `armed<=0`;
  - go to IDLE.
- Re-arm: `armed` is set in any cycle where `Frame_En` is low. A level held high therefore produces exactly one frame.
- Checksum, in 8-bit arithmetic with carries discarded:
  - each payload byte is accumulated as it is loaded into `TX_Data`;
  - mode 0: the sent byte is `(~sum)+1`;
  - mode 1: the sent byte is the XOR of the payload bytes.
- Frame length is `NBYTES + HDR_EN + 1` bytes.
- Changes on `Frame_Data` after capture have no effect on the frame in progress.

## Timing
- Reset values: `TX_En_Sig=0`, `TX_Data=8'h00`, `Frame_Done=0`, `Frame_Busy=0`, state IDLE, `armed=1`, accumulator 0, `idx=0`.
- Cycle 0: `Frame_En` is sampled high. Cycle 1: `TX_Data` is valid. Cycle 2: `TX_En_Sig=1`.
- `TX_Data` is stable for at least one cycle before `TX_En_Sig` rises and is held until `TX_Done_Sig`.
- Each byte costs 2 cycles plus the UART time. `TX_En_Sig` is low for exactly one cycle (LOAD) between bytes.
- `Frame_Done` is high in the cycle after the final `TX_Done_Sig`. `Frame_Busy` falls one cycle later.
- Earliest next frame: `Frame_En` low for at least one cycle, then high in IDLE.
- Asserting `RSTn` low mid-frame immediately returns all outputs to their reset values and abandons the frame; no partial checksum is sent.
- A `TX_Done_Sig` received while in IDLE or DONE is ignored.

## Structure
- Package `tx_frame_pkg` holds:
  - the state encoding localparams (IDLE, LOAD, SEND, DONE);
  - `CK_SUM2C=0`, `CK_XOR=1`;
  - a function returning the frame length from `NBYTES`/`HDR_EN`.
- Sub-module `tx_cksum_acc` contains the 8-bit accumulator, with inputs clear, byte-valid, byte, and the `CK_MODE` parameter, and output checksum. The top-level FSM instantiates it once.
- Byte select is a mux on the shadow register indexed by `idx` (width `$clog2(NBYTES+1)`).

## Test plan
- **Mode 0 frame:** `NBYTES=5`, `HDR_EN=0`, `Frame_Data=40'h0102030405`, UART model with 10-cycle `TX_Done_Sig` delay → bytes 01,02,03,04,05,F1; `Frame_Done` pulses once for 1 cycle.
- **XOR with header:** `CK_MODE=1`, `HDR_EN=1`, same data → bytes AA,01,02,03,04,05,01.
- **Wrap-around:** data `40'hFFFFFFFF05` → sum 0x01, checksum byte FF.
- **Held level:** `Frame_En` held high for 3 frame-times → exactly one frame. Drop `Frame_En` for 1 cycle and raise it again → the second frame starts 1 cycle later.
- **Data change mid-frame:** change `Frame_Data` to all-zeros after the first byte → the frame still carries the captured bytes and checksum F1.
- **Reset mid-frame and stray pulse:** pull `RSTn` low during byte 3 → `TX_En_Sig`, `Busy`, `Done` and `TX_Data` are 0 immediately; the next request sends a full, correct frame. A `TX_Done_Sig` pulse in IDLE causes no output change.

Source files
------------

// File: rtl/tx_frame_pkg.sv
// rtl/tx_frame_pkg.sv - state encoding, checksum modes and frame-length helper for the tx frame packer
// No ports: imported by tx_cksum_acc and tx_frame_packer.
package tx_frame_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int CK_SUM2C = 0;
  localparam int CK_XOR   = 1;

  // Bytes on the wire per frame: optional header, payload, checksum.
  function automatic int frame_len(input int nbytes, input int hdr_en);
    return nbytes + hdr_en + 1;
  endfunction

endpackage

// File: rtl/tx_cksum_acc.sv
// rtl/tx_cksum_acc.sv - 8-bit running checksum (two's-complement sum or XOR)
// Ports:
//   CLK, RSTn  clock, asynchronous active-low reset
//   clr        restart the accumulation from zero
//   byte_vld   fold byte_in into the accumulator this cycle
//   byte_in    payload byte
//   cksum      checksum byte to transmit for the bytes folded so far
module tx_cksum_acc
  import tx_frame_pkg::*;
#(
  parameter int CK_MODE = CK_SUM2C
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       clr,
  input  logic       byte_vld,
  input  logic [7:0] byte_in,
  output logic [7:0] cksum
);

  logic [7:0] acc;
  logic [7:0] base;
  logic [7:0] acc_nxt;

  // clr and byte_vld may coincide: the first payload byte is folded into a
  // freshly cleared accumulator in the same cycle.
  always_comb begin
    base    = clr ? 8'h00 : acc;
    acc_nxt = base;
    if (byte_vld) begin
      if (CK_MODE == CK_XOR) acc_nxt = base ^ byte_in;
      else                   acc_nxt = base + byte_in;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) acc <= 8'h00;
    else       acc <= acc_nxt;
  end

  assign cksum = (CK_MODE == CK_XOR) ? acc : (~acc + 8'd1);

endmodule

// File: rtl/tx_frame_packer.sv
// rtl/tx_frame_packer.sv - frames a wide word into header/payload/checksum bytes for a byte UART
// Ports:
//   CLK, RSTn    clock, asynchronous active-low reset
//   Frame_En     level request, sampled in IDLE; must go low once to re-arm
//   Frame_Data   payload word, most significant byte sent first
//   Frame_Busy   high from capture until Frame_Done drops
//   Frame_Done   one-cycle pulse after the checksum byte completes
//   TX_Done_Sig  one-cycle pulse from the UART when a byte has finished
//   TX_En_Sig    UART send enable, held until TX_Done_Sig
//   TX_Data      byte presented to the UART
module tx_frame_packer
  import tx_frame_pkg::*;
#(
  parameter int         NBYTES   = 5,
  parameter int         HDR_EN   = 0,
  parameter logic [7:0] HDR_BYTE = 8'hAA,
  parameter int         CK_MODE  = CK_SUM2C
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                Frame_En,
  input  logic [8*NBYTES-1:0] Frame_Data,
  output logic                Frame_Busy,
  output logic                Frame_Done,
  input  logic                TX_Done_Sig,
  output logic                TX_En_Sig,
  output logic [7:0]          TX_Data
);

  localparam int              IDXW     = $clog2(NBYTES + 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES);

  logic [1:0]          state, state_nxt;
  logic [8*NBYTES-1:0] shadow, shadow_nxt;
  // idx counts payload bytes already loaded into TX_Data, so it doubles as
  // the shadow index of the next payload byte.
  logic [IDXW-1:0]     idx, idx_nxt;
  logic [7:0]          tx_data_nxt;
  logic                tx_en_nxt, done_nxt, busy_nxt;
  logic                armed, armed_nxt;
  // Set once the checksum byte has been loaded; the next TX_Done ends the frame.
  logic                ck_phase, ck_phase_nxt;

  logic                start;
  logic                acc_clr, acc_vld;
  logic [7:0]          acc_byte, cksum, sel_byte, first_byte;

  assign start      = (state == ST_IDLE) && Frame_En && armed;
  assign first_byte = Frame_Data[8*NBYTES-1 -: 8];

  always_comb begin
    sel_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx == IDXW'(k)) sel_byte = shadow[8*(NBYTES-1-k) +: 8];
    end
  end

  tx_cksum_acc #(.CK_MODE(CK_MODE)) u_acc (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .clr      (acc_clr),
    .byte_vld (acc_vld),
    .byte_in  (acc_byte),
    .cksum    (cksum)
  );

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: if (TX_Done_Sig) state_nxt = ck_phase ? ST_DONE : ST_LOAD;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    shadow_nxt   = shadow;
    idx_nxt      = idx;
    tx_data_nxt  = TX_Data;
    tx_en_nxt    = TX_En_Sig;
    done_nxt     = Frame_Done;
    busy_nxt     = Frame_Busy;
    armed_nxt    = armed;
    ck_phase_nxt = ck_phase;
    acc_clr      = 1'b0;
    acc_vld      = 1'b0;
    acc_byte     = sel_byte;
    case (state)
      ST_IDLE: begin
        if (start) begin
          shadow_nxt   = Frame_Data;
          acc_clr      = 1'b1;
          busy_nxt     = 1'b1;
          ck_phase_nxt = 1'b0;
          if (HDR_EN != 0) begin
            tx_data_nxt = HDR_BYTE;
            idx_nxt     = '0;
          end else begin
            // Shadow is not loaded yet, so byte 0 comes straight off the input.
            tx_data_nxt = first_byte;
            acc_byte    = first_byte;
            acc_vld     = 1'b1;
            idx_nxt     = IDXW'(1);
          end
        end
      end
      ST_LOAD: tx_en_nxt = 1'b1;
      ST_SEND: begin
        if (TX_Done_Sig) begin
          tx_en_nxt = 1'b0;
          if (ck_phase) begin
            done_nxt = 1'b1;
          end else if (idx == IDX_LAST) begin
            tx_data_nxt  = cksum;
            ck_phase_nxt = 1'b1;
          end else begin
            tx_data_nxt = sel_byte;
            acc_vld     = 1'b1;
            idx_nxt     = idx + IDXW'(1);
          end
        end
      end
      ST_DONE: begin
        done_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        armed_nxt = 1'b0;
        idx_nxt   = '0;
      end
      default: ;
    endcase
    // A low request re-arms, and wins over the clear in DONE so a drop
    // during DONE is not lost.
    if (!Frame_En) armed_nxt = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      shadow     <= '0;
      idx        <= '0;
      TX_Data    <= 8'h00;
      TX_En_Sig  <= 1'b0;
      Frame_Done <= 1'b0;
      Frame_Busy <= 1'b0;
      armed      <= 1'b1;
      ck_phase   <= 1'b0;
    end else begin
      shadow     <= shadow_nxt;
      idx        <= idx_nxt;
      TX_Data    <= tx_data_nxt;
      TX_En_Sig  <= tx_en_nxt;
      Frame_Done <= done_nxt;
      Frame_Busy <= busy_nxt;
      armed      <= armed_nxt;
      ck_phase   <= ck_phase_nxt;
    end
  end

endmodule

// File: tb/tb_tx_frame_packer.sv
// tb/tb_tx_frame_packer.sv - self-checking bench for tx_frame_packer (sum mode and XOR+header mode)
module tb_tx_frame_packer;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        Frame_En = 1'b0;
  logic [39:0] Frame_Data = 40'h0;
  logic        stray = 1'b0;

  logic       busy0, done0, en0, busy1, done1, en1;
  logic [7:0] data0, data1;
  logic [1:0] tdone = 2'b00;
  logic       tdone0_in, tdone1_in;

  assign tdone0_in = tdone[0] | stray;
  assign tdone1_in = tdone[1] | stray;

  always #5 CLK = ~CLK;

  tx_frame_packer #(.NBYTES(5), .HDR_EN(0), .HDR_BYTE(8'hAA), .CK_MODE(0)) u_dut0 (
    .CLK(CLK), .RSTn(RSTn), .Frame_En(Frame_En), .Frame_Data(Frame_Data),
    .Frame_Busy(busy0), .Frame_Done(done0), .TX_Done_Sig(tdone0_in),
    .TX_En_Sig(en0), .TX_Data(data0)
  );

  tx_frame_packer #(.NBYTES(5), .HDR_EN(1), .HDR_BYTE(8'hAA), .CK_MODE(1)) u_dut1 (
    .CLK(CLK), .RSTn(RSTn), .Frame_En(Frame_En), .Frame_Data(Frame_Data),
    .Frame_Busy(busy1), .Frame_Done(done1), .TX_Done_Sig(tdone1_in),
    .TX_En_Sig(en1), .TX_Data(data1)
  );

  // UART models: latch TX_Data when TX_En_Sig rises, answer with a TX_Done
  // pulse 10 cycles later, then wait for TX_En_Sig to drop before the next byte.
  int         busy_m [2];
  int         cnt_m  [2];
  bit         wl     [2];
  bit         prev_d [2];
  logic [7:0] cap    [2][256];
  int         ncap   [2];
  int         ndone  [2];
  int         nlong  [2];

  always @(negedge CLK) begin
    for (int u = 0; u < 2; u++) begin
      logic       en_u, dn_u;
      logic [7:0] dt_u;
      en_u = (u == 0) ? en0 : en1;
      dn_u = (u == 0) ? done0 : done1;
      dt_u = (u == 0) ? data0 : data1;
      if (!RSTn) begin
        busy_m[u] = 0;
        wl[u]     = 1'b0;
        prev_d[u] = 1'b0;
        tdone[u]  = 1'b0;
      end else begin
        tdone[u] = 1'b0;
        if (wl[u]) begin
          if (!en_u) wl[u] = 1'b0;
        end else if (busy_m[u] == 0 && en_u) begin
          busy_m[u] = 1;
          cnt_m[u]  = 0;
          cap[u][ncap[u] % 256] = dt_u;
          ncap[u]++;
        end else if (busy_m[u] != 0) begin
          cnt_m[u]++;
          if (cnt_m[u] == 10) begin
            tdone[u]  = 1'b1;
            busy_m[u] = 0;
            wl[u]     = 1'b1;
          end
        end
        if (dn_u) begin
          ndone[u]++;
          if (prev_d[u]) nlong[u]++;
        end
        prev_d[u] = dn_u;
      end
    end
  end

  int nchk = 0;
  int nerr = 0;
  int s0, s1, d0, d1, l0, l1;

  typedef struct {
    logic [39:0] data;
    logic [7:0]  ck_sum;
    logic [7:0]  ck_xor;
    bit          mid;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic snap();
    s0 = ncap[0]; s1 = ncap[1];
    d0 = ndone[0]; d1 = ndone[1];
    l0 = nlong[0]; l1 = nlong[1];
  endtask

  task automatic wait_frames(input int budget);
    int c = 0;
    while ((ndone[0] < d0 + 1 || ndone[1] < d1 + 1) && c < budget) begin
      @(negedge CLK);
      c++;
    end
    if (c >= budget) begin
      nchk++;
      nerr++;
      $display("FAIL frame_timeout: done0=%0d done1=%0d after %0d cycles", ndone[0] - d0, ndone[1] - d1, c);
    end
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c = 0;
    while (ncap[0] < s0 + n && c < budget) begin
      @(negedge CLK);
      c++;
    end
    if (c >= budget) begin
      nchk++;
      nerr++;
      $display("FAIL byte_timeout: got %0d bytes expected %0d", ncap[0] - s0, n);
    end
  endtask

  task automatic check_frame(input logic [39:0] data, input logic [7:0] cks, input logic [7:0] ckx);
    chk("len0", ncap[0] - s0, 6);
    for (int b = 0; b < 5; b++) chk("pay0", int'(cap[0][(s0 + b) % 256]), int'(data[8*(4-b) +: 8]));
    chk("ck0", int'(cap[0][(s0 + 5) % 256]), int'(cks));
    chk("done0", ndone[0] - d0, 1);
    chk("pulse0", nlong[0] - l0, 0);
    chk("len1", ncap[1] - s1, 7);
    chk("hdr1", int'(cap[1][s1 % 256]), 'hAA);
    for (int b = 0; b < 5; b++) chk("pay1", int'(cap[1][(s1 + 1 + b) % 256]), int'(data[8*(4-b) +: 8]));
    chk("ck1", int'(cap[1][(s1 + 6) % 256]), int'(ckx));
    chk("done1", ndone[1] - d1, 1);
    chk("pulse1", nlong[1] - l1, 0);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge CLK);
    snap();
    Frame_Data = v.data;
    Frame_En   = 1'b1;
    if (v.mid) begin
      wait_bytes(1, 100);
      Frame_Data = 40'h0;
    end
    wait_frames(400);
    Frame_En = 1'b0;
    repeat (3) @(negedge CLK);
    check_frame(v.data, v.ck_sum, v.ck_xor);
  endtask

  initial begin
    logic [7:0] held;
    for (int u = 0; u < 2; u++) begin
      ncap[u] = 0; ndone[u] = 0; nlong[u] = 0;
    end
    vecs[0] = '{data: 40'h0102030405, ck_sum: 8'hF1, ck_xor: 8'h01, mid: 1'b0};
    vecs[1] = '{data: 40'hFFFFFFFF05, ck_sum: 8'hFF, ck_xor: 8'h05, mid: 1'b0};
    vecs[2] = '{data: 40'h0000000000, ck_sum: 8'h00, ck_xor: 8'h00, mid: 1'b0};
    vecs[3] = '{data: 40'h123456789A, ck_sum: 8'h52, ck_xor: 8'h92, mid: 1'b0};
    vecs[4] = '{data: 40'h0102030405, ck_sum: 8'hF1, ck_xor: 8'h01, mid: 1'b1};

    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_en", int'(en0), 0);
    chk("rst_data", int'(data0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_busy", int'(busy0), 0);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    // Stray TX_Done while idle
    snap();
    stray = 1'b1;
    @(negedge CLK);
    stray = 1'b0;
    repeat (20) @(negedge CLK);
    chk("stray_en", int'(en0), 0);
    chk("stray_busy", int'(busy0), 0);
    chk("stray_data", int'(data0), 0);
    chk("stray_bytes", ncap[0] - s0, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Held request gives one frame; a one-cycle drop re-arms
    @(negedge CLK);
    snap();
    Frame_Data = 40'h0102030405;
    Frame_En   = 1'b1;
    repeat (300) @(negedge CLK);
    chk("held_frames0", ndone[0] - d0, 1);
    chk("held_frames1", ndone[1] - d1, 1);
    chk("held_bytes0", ncap[0] - s0, 6);
    Frame_En = 1'b0;
    @(negedge CLK);
    Frame_En = 1'b1;
    snap();
    chk("rearm_busy_pre", int'(busy0), 0);
    @(negedge CLK);
    chk("rearm_busy_post", int'(busy0), 1);
    wait_frames(400);
    Frame_En = 1'b0;
    repeat (3) @(negedge CLK);
    check_frame(40'h0102030405, 8'hF1, 8'h01);

    // Reset during byte 3
    snap();
    Frame_Data = 40'h123456789A;
    Frame_En   = 1'b1;
    wait_bytes(3, 200);
    repeat (4) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("mrst_en0", int'(en0), 0);
    chk("mrst_busy0", int'(busy0), 0);
    chk("mrst_done0", int'(done0), 0);
    chk("mrst_data0", int'(data0), 0);
    chk("mrst_en1", int'(en1), 0);
    chk("mrst_data1", int'(data1), 0);
    Frame_En = 1'b0;
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    repeat (30) @(negedge CLK);
    chk("mrst_nodone", ndone[0] - d0, 0);
    chk("mrst_nobytes", ncap[0] - s0, 3);
    run_vec(vecs[3]);

    // Stray TX_Done after a frame must not disturb the held checksum byte
    held = data0;
    snap();
    stray = 1'b1;
    @(negedge CLK);
    stray = 1'b0;
    repeat (5) @(negedge CLK);
    chk("stray2_data", int'(data0), int'(held));
    chk("stray2_en", int'(en0), 0);
    chk("stray2_done", ndone[0] - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
